pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL: clk  in  1  single rising-edge clock for all state.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL: Stall  in  1  hold PC and suppress all redirects this cycle.
REQ-004 SHALL: PCSrc  in  2  next-PC select: 0 sequential, 1 branch, 2 jump, 3 jr.
REQ-005 SHALL: BranchTaken  in  1  branch condition; honoured only when PCSrc=1.
REQ-006 SHALL: BranchOffset  in  16  signed word offset.
REQ-007 SHALL: JumpTarget  in  26  J-format target field.
REQ-008 SHALL: JrTarget  in  32  register value for jr.
REQ-009 SHALL: IRQ  in  1  level interrupt request from the timer/peripheral.
REQ-010 SHALL: Illegal  in  1  current instruction undecodable.
REQ-011 SHALL: PC  out  32  current instruction address; bit 31 is the kernel flag.
REQ-012 SHALL: InstAddress  out  8  word index PC[9:2] to the instruction ROM.
REQ-013 SHALL: KernelMode  out  1  equals PC[31].
REQ-014 SHALL: EPCWrite  out  1  one-cycle strobe to write EPCValue into $k0.
REQ-015 SHALL: EPCValue  out  32  return address for the handler.
REQ-016 SHALL: IrqAck  out  1  one-cycle strobe when an interrupt is taken.

Function
REQ-017 SHALL: PCPlus4 = {PC[31], PC[30:0]+4}; bit 31 is preserved, and bits 30:0 wrap modulo 2^31.
REQ-018 SHALL: branch target = PCPlus4 + (sign-extended BranchOffset << 2); bit 31 is forced to PC[31].
REQ-019 SHALL: jump target = {PC[31:28], JumpTarget, 2'b00}.
REQ-020 SHALL: jr target = {PC[31] & JrTarget[31], JrTarget[30:0]}; jr can clear the kernel flag but never set it.
REQ-021 SHALL: NormalNext = PCPlus4 for PCSrc=0, or for PCSrc=1 with BranchTaken=0; otherwise it is the selected target.
REQ-022 SHALL: IrqPending is set on any cycle with IRQ=1 and cleared on the cycle an interrupt is taken.
REQ-023 SHALL: Redirect priority per non-stalled cycle is exception > interrupt > NormalNext.
REQ-024 SHALL: when an interrupt is taken (IrqPending=1, KernelMode=0, no exception), the next PC is 0x80000004, EPCValue = NormalNext, and EPCWrite=1 and IrqAck=1 in that cycle.
REQ-025 SHALL: interrupts are never taken while KernelMode=1; they remain pending.
REQ-026 SHALL: when Stall=1, PC holds, EPCWrite=0, IrqAck=0, and IrqPending may still be set.
REQ-027 SHALL: EPCWrite and IrqAck are combinational in the same cycle as the redirect decision; PC updates at the following edge (latency 1).
REQ-028 SHALL: FSM states are BOOT and RUN; BOOT is entered on reset and lasts one cycle with PC=0x80000000 and no redirects; BOOT always moves to RUN.
REQ-029 SHALL: IrqPending is ignored in BOOT.

Reset
REQ-030 SHALL: on reset, PC=0x80000000, IrqPending=0, and state=BOOT.
REQ-031 SHALL: during reset, InstAddress=0, KernelMode=1, EPCWrite=0, IrqAck=0, and EPCValue=0.
REQ-032 SHALL: reset asserted mid-operation overrides Stall, IRQ, and Illegal in that cycle.

Configuration
REQ-033 SHALL: with PC_EXCEPTION_EN defined, Illegal=1 in RUN while not stalled redirects to 0x80000008 with EPCValue=PCPlus4 and EPCWrite=1, independent of KernelMode.
REQ-034 SHALL: without PC_EXCEPTION_EN, Illegal is ignored and only the interrupt path can raise EPCWrite.

Structure
REQ-035 SHALL: the shared package cpu_pkg holds the PCSrc encodings and the constants RESET_VECTOR=0x80000000, IRQ_VECTOR=0x80000004, and EXC_VECTOR=0x80000008.
REQ-036 SHALL: the combinational next-address selection (REQ-017..021) is the sub-module pc_next_mux; the registers, FSM, and priority logic stay in pc_fetch_unit.

Verification
REQ-037 SHALL: reset, then 3 cycles with PCSrc=0 -> PC sequence 0x80000000, 0x80000000 (BOOT), 0x80000004, 0x80000008.
REQ-038 SHALL: PC=0x80000040, PCSrc=3, JrTarget=0x00000044 -> PC=0x00000044 and KernelMode=0; then PCSrc=3, JrTarget=0x80000100 -> PC=0x00000100.
REQ-039 SHALL: user PC=0x00000068, IRQ pulse of 1 cycle, PCSrc=0 -> EPCWrite=1, IrqAck=1, EPCValue=0x0000006C, next PC=0x80000004.
REQ-040 SHALL: IRQ asserted at PC=0x80000010 (kernel) -> no ack; after jr to 0x00000020 -> ack in the first user cycle with EPCValue=0x00000024.
REQ-041 SHALL: PC=0x00000080, PCSrc=1, BranchTaken=1, BranchOffset=0xFFE3, plus Stall=1 for 2 cycles -> PC holds for 2 cycles, then PC=0x00000010.
REQ-042 SHALL: with PC_EXCEPTION_EN defined, PC=0x00000030, Illegal=1, and IRQ pending -> EXC_VECTOR taken, EPCValue=0x00000034, IrqAck=0, and the interrupt stays pending.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings and the fixed
// reset, interrupt and exception vectors.
package cpu_pkg;

    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_JR     = 2'd3;

    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0008;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: control inputs from decode/peripherals and PC/EPC outputs.
// The slave modport belongs to the fetch unit, the master to its driver.
interface pc_fetch_unit_if;

    logic        Stall;
    logic [1:0]  PCSrc;
    logic        BranchTaken;
    logic [15:0] BranchOffset;
    logic [25:0] JumpTarget;
    logic [31:0] JrTarget;
    logic        IRQ;
    logic        Illegal;

    logic [31:0] PC;
    logic [7:0]  InstAddress;
    logic        KernelMode;
    logic        EPCWrite;
    logic [31:0] EPCValue;
    logic        IrqAck;

    modport slave (
        input  Stall, PCSrc, BranchTaken, BranchOffset, JumpTarget, JrTarget, IRQ, Illegal,
        output PC, InstAddress, KernelMode, EPCWrite, EPCValue, IrqAck
    );

    modport master (
        output Stall, PCSrc, BranchTaken, BranchOffset, JumpTarget, JrTarget, IRQ, Illegal,
        input  PC, InstAddress, KernelMode, EPCWrite, EPCValue, IrqAck
    );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-address selection for sequential, branch, jump and jr flow.
// Bit 31 is the kernel flag and is never produced by address arithmetic.
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] normal_next
);

    logic [31:0] offset_ext;
    logic [31:0] branch_sum;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic [31:0] jr_addr;

    assign pc_plus4    = {pc[31], pc[30:0] + 31'd4};
    assign offset_ext  = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign branch_sum  = pc_plus4 + offset_ext;
    assign branch_addr = {pc[31], branch_sum[30:0]};
    assign jump_addr   = {pc[31:28], jump_target, 2'b00};
    // jr may drop to user mode but can never enter kernel mode
    assign jr_addr     = {pc[31] & jr_target[31], jr_target[30:0]};

    always_comb begin
        normal_next = pc_plus4;
        case (pc_src)
            PCSRC_SEQ:    normal_next = pc_plus4;
            PCSRC_BRANCH: normal_next = branch_taken ? branch_addr : pc_plus4;
            PCSRC_JUMP:   normal_next = jump_addr;
            PCSRC_JR:     normal_next = jr_addr;
            default:      normal_next = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, BOOT/RUN sequencing and exception/interrupt redirect priority.
// Define PC_EXCEPTION_EN to redirect undecodable instructions to EXC_VECTOR.
module pc_fetch_unit
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.slave  bus
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [31:0] pc_q, pc_d;
    logic        irq_pending_q, irq_pending_d;
    logic [0:0]  state_q, state_d;

    logic [31:0] pc_plus4;
    logic [31:0] normal_next;
    logic        take_exc;
    logic        take_irq;
    logic        epc_write;
    logic [31:0] epc_value;
    logic [31:0] pc_out;

    pc_next_mux u_next_mux (
        .pc            (pc_q),
        .pc_src        (bus.PCSrc),
        .branch_taken  (bus.BranchTaken),
        .branch_offset (bus.BranchOffset),
        .jump_target   (bus.JumpTarget),
        .jr_target     (bus.JrTarget),
        .pc_plus4      (pc_plus4),
        .normal_next   (normal_next)
    );

    always_comb begin
        pc_d          = pc_q;
        state_d       = ST_RUN;
        irq_pending_d = irq_pending_q | bus.IRQ;
        take_exc      = 1'b0;
        take_irq      = 1'b0;
        epc_write     = 1'b0;
        epc_value     = 32'h0;

        if (state_q == ST_BOOT) begin
            if (!bus.Stall) begin
                pc_d = pc_plus4;
            end
        end else if (!bus.Stall) begin
`ifdef PC_EXCEPTION_EN
            take_exc = bus.Illegal;
`else
            take_exc = 1'b0;
`endif
            take_irq = !take_exc && irq_pending_q && !pc_q[31];

            if (take_exc) begin
                pc_d      = EXC_VECTOR;
                epc_write = 1'b1;
                epc_value = pc_plus4;
            end else if (take_irq) begin
                pc_d          = IRQ_VECTOR;
                epc_write     = 1'b1;
                epc_value     = normal_next;
                irq_pending_d = 1'b0;
            end else begin
                pc_d = normal_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            irq_pending_q <= 1'b0;
            state_q       <= ST_BOOT;
        end else begin
            pc_q          <= pc_d;
            irq_pending_q <= irq_pending_d;
            state_q       <= state_d;
        end
    end

    // Outputs read as the reset state for the whole time reset is held
    assign pc_out          = reset ? RESET_VECTOR : pc_q;
    assign bus.PC          = pc_out;
    assign bus.InstAddress = pc_out[9:2];
    assign bus.KernelMode  = pc_out[31];
    assign bus.EPCWrite    = epc_write & ~reset;
    assign bus.IrqAck      = take_irq & ~reset;
    assign bus.EPCValue    = reset ? 32'h0 : epc_value;

endmodule
